// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with valid/ready handshakes and multi-cycle shift-add multiply
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             c,
  output logic             s,
  output logic             p,
  output logic             z,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_c;
  logic               alu_err;
  logic               accept;
  logic               is_mul;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !rst;
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (opcode == 4'd8);

  // Single-cycle datapath; opcode 8 falls into the illegal branch and is only
  // overridden by the multiplier path when MUL_EN is set.
  always_comb begin
    alu_y   = '0;
    alu_c   = 1'b0;
    alu_err = 1'b0;
    case (opcode)
      4'd0: {alu_c, alu_y} = {1'b0, a} + {1'b0, b};
      4'd1: begin
        alu_y = a - b;
        alu_c = (a < b);
      end
      4'd2: alu_y = a & b;
      4'd3: alu_y = a | b;
      4'd4: alu_y = a ^ b;
      4'd5: alu_y = ~a;
      4'd6: begin
        alu_y = {a[WIDTH-2:0], 1'b0};
        alu_c = a[WIDTH-1];
      end
      4'd7: begin
        alu_y = {1'b0, a[WIDTH-1:1]};
        alu_c = a[0];
      end
      default: alu_err = 1'b1;
    endcase
  end

  // One multiplier bit per cycle, LSB first, multiplicand shifted left.
  assign acc_step = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      y         <= '0;
      y_hi      <= '0;
      c         <= 1'b0;
      s         <= 1'b0;
      p         <= 1'b0;
      z         <= 1'b0;
      err       <= 1'b0;
      count     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state  <= MUL_BUSY;
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              acc    <= '0;
              count  <= CW'(WIDTH - 1);
            end else begin
              y         <= alu_y;
              y_hi      <= '0;
              c         <= alu_c;
              err       <= alu_err;
              s         <= alu_y[WIDTH-1];
              p         <= ~^alu_y;
              z         <= (alu_y == '0);
              out_valid <= 1'b1;
            end
          end
        end
        MUL_BUSY: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - 1'b1;
          if (count == '0) begin
            y         <= acc_step[WIDTH-1:0];
            y_hi      <= acc_step[2*WIDTH-1:WIDTH];
            c         <= |acc_step[2*WIDTH-1:WIDTH];
            err       <= 1'b0;
            s         <= acc_step[WIDTH-1];
            p         <= ~^acc_step[WIDTH-1:0];
            z         <= (acc_step[WIDTH-1:0] == '0);
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;
  logic [15:0] y_hi;
  logic        c, s, p, z, err;

  logic        in_ready2, out_valid2;
  logic [15:0] y2, y_hi2;
  logic        c2, s2, p2, z2, err2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_hi(y_hi), .c(c), .s(s), .p(p), .z(z), .err(err)
  );

  alu_seq #(.WIDTH(16), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid2), .out_ready(out_ready),
    .y(y2), .y_hi(y_hi2), .c(c2), .s(s2), .p(p2), .z(z2), .err(err2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [15:0] ey, input logic [15:0] eyh,
                           input logic ec, input logic es, input logic ep, input logic ez,
                           input logic eerr);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".y"},     64'(y),         64'(ey));
    check({tag, ".y_hi"},  64'(y_hi),      64'(eyh));
    check({tag, ".c"},     64'(c),         64'(ec));
    check({tag, ".s"},     64'(s),         64'(es));
    check({tag, ".p"},     64'(p),         64'(ep));
    check({tag, ".z"},     64'(z),         64'(ez));
    check({tag, ".err"},   64'(err),       64'(eerr));
  endtask

  // Present one op for one cycle; returns on the negedge right after acceptance
  // with the operand inputs scrambled so late changes would be noticed.
  task automatic send(input logic [3:0] op, input logic [15:0] aa, input logic [15:0] bb);
    @(negedge clk);
    opcode = op; a = aa; b = bb; in_valid = 1'b1; out_ready = 1'b1;
    check("send_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
  endtask

  task automatic wait_mul(input string tag, input int exp_lat);
    int lat = -1;
    logic ready_seen = 1'b0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      if (in_ready) ready_seen = 1'b1;
      @(negedge clk);
      if (out_valid) lat = k;
    end
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".busy_ready"}, 64'(ready_seen), 64'd0);
  endtask

  logic [15:0] sw_y [8];
  logic        sw_c [8];
  logic        sw_p [8];
  logic        sw_s [8];

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; opcode = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.in_ready",  64'(in_ready),  64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.y",         64'(y),         64'd0);
    check("rst.err",       64'(err),       64'd0);
    rst = 1'b0;

    send(4'd0, 16'd120, 16'd100);
    check_res("add", 16'd220, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(4'd1, 16'd100, 16'd120);
    check_res("sub_neg", 16'hFFEC, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send(4'd1, 16'd120, 16'd120);
    check_res("sub_zero", 16'h0000, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send(4'd0, 16'hFFFF, 16'h0001);
    check_res("add_carry", 16'h0000, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    send(4'd8, 16'd120, 16'd100);
    check("mul1.valid_early", 64'(out_valid), 64'd0);
    wait_mul("mul1", 16);
    check_res("mul1", 16'h2EE0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(4'd8, 16'hFFFF, 16'hFFFF);
    wait_mul("mul2", 16);
    check_res("mul2", 16'h0001, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    send(4'd9, 16'h1234, 16'h5678);
    check_res("op9", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    send(4'd8, 16'd3, 16'd5);
    check("nomul.valid", 64'(out_valid2), 64'd1);
    check("nomul.y",     64'(y2),         64'd0);
    check("nomul.err",   64'(err2),       64'd1);
    check("nomul.z",     64'(z2),         64'd1);
    check("nomul.p",     64'(p2),         64'd1);
    wait_mul("mul3", 16);
    check_res("mul3", 16'd15, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Back-to-back sweep, a=0x8001 b=0x0003
    sw_y = '{16'h8004, 16'h7FFE, 16'h0001, 16'h8003, 16'h8002, 16'h7FFE, 16'h0002, 16'h4000};
    sw_c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    sw_p = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    sw_s = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("sweep%0d.valid", i - 1), 64'(out_valid), 64'd1);
        check($sformatf("sweep%0d.y", i - 1),     64'(y),         64'(sw_y[i-1]));
        check($sformatf("sweep%0d.c", i - 1),     64'(c),         64'(sw_c[i-1]));
        check($sformatf("sweep%0d.p", i - 1),     64'(p),         64'(sw_p[i-1]));
        check($sformatf("sweep%0d.s", i - 1),     64'(s),         64'(sw_s[i-1]));
        check($sformatf("sweep%0d.err", i - 1),   64'(err),       64'd0);
      end
      if (i < 8) begin
        check($sformatf("sweep%0d.ready", i), 64'(in_ready), 64'd1);
        opcode = 4'(i); a = 16'h8001; b = 16'h0003; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end

    // Backpressure: result held, pending op waits, then replaces it
    send(4'd0, 16'd1, 16'd2);
    check("bp.first", 64'(y), 64'd3);
    opcode = 4'd4; a = 16'd5; b = 16'd3; in_valid = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp.hold%0d.valid", k), 64'(out_valid), 64'd1);
      check($sformatf("bp.hold%0d.y", k),     64'(y),         64'd3);
      check($sformatf("bp.hold%0d.ready", k), 64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp.new.valid", 64'(out_valid), 64'd1);
    check("bp.new.y",     64'(y),         64'd6);
    @(negedge clk);
    check("bp.drained", 64'(out_valid), 64'd0);

    // Reset five cycles into a multiply
    send(4'd8, 16'd7, 16'd9);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rstmul.in_ready", 64'(in_ready),  64'd0);
    check("rstmul.valid",    64'(out_valid), 64'd0);
    check("rstmul.y",        64'(y),         64'd0);
    check("rstmul.y_hi",     64'(y_hi),      64'd0);
    check("rstmul.flags",    64'({c, s, p, z, err}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmul.ready_after", 64'(in_ready), 64'd1);
    begin
      logic seen = 1'b0;
      for (int k = 0; k < 25; k++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      check("rstmul.no_result", 64'(seen), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
